// File: rtl/prio_arbiter.sv
// prio_arbiter: registered priority arbiter for N requesters.
// A winner is chosen from req while idle and its grant is held until the
// owner pulses done or drops its own request. MODE=0 gives fixed priority
// (index N-1 highest); MODE=1 rotates a search pointer below the last owner.
//
// Handshake: req[k] is a level request. A grant is presented on gnt/gnt_idx
// with gnt_valid=1 one cycle after req is sampled in IDLE. The owner ends the
// grant with a one-cycle done pulse or by dropping req[k]; both in the same
// cycle count as a single release. Every release is followed by at least one
// cycle with gnt_valid=0 before the next grant appears.
module prio_arbiter #(
  parameter int N    = 8,
  parameter int W    = $clog2(N),
  parameter int MODE = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         done,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_idx,
  output logic         gnt_valid
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [W-1:0] LAST_IDX = W'(N - 1);

  state_t       state;
  logic [W-1:0] ptr;

  logic         win_found;
  logic [W-1:0] win_idx;
  logic [N-1:0] win_onehot;
  logic         release_now;
  logic [W-1:0] ptr_next;

  // Winner selection from the current request vector and search pointer.
  always_comb begin
    logic [W-1:0] cand;
    int           k;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    k         = 0;
    if (MODE == 0) begin
      // Ascending scan: the last set bit seen is the highest index.
      for (int i = 0; i < N; i++) begin
        cand = W'(i);
        if (req[cand]) begin
          win_found = 1'b1;
          win_idx   = cand;
        end
      end
    end else begin
      // Descend from ptr, wrapping from 0 to N-1, first set bit wins.
      for (int i = 0; i < N; i++) begin
        k = int'(ptr) - i;
        if (k < 0) k = k + N;
        cand = W'(k);
        if (!win_found && req[cand]) begin
          win_found = 1'b1;
          win_idx   = cand;
        end
      end
    end
  end

  // One-hot form of the selected winner.
  always_comb begin
    win_onehot          = '0;
    win_onehot[win_idx] = 1'b1;
  end

  // Release detection and the pointer value that follows a release.
  always_comb begin
    release_now = done || !req[gnt_idx];
    if (gnt_idx == '0) ptr_next = LAST_IDX;
    else               ptr_next = gnt_idx - 1'b1;
  end

  // Arbiter FSM with registered grant outputs and rotating pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      ptr       <= LAST_IDX;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            state     <= GRANT;
            gnt       <= win_onehot;
            gnt_idx   <= win_idx;
            gnt_valid <= 1'b1;
          end else begin
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
          end
        end
        GRANT: begin
          if (release_now) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            if (MODE == 1) ptr <= ptr_next;
          end
        end
        default: begin
          state     <= IDLE;
          gnt       <= '0;
          gnt_idx   <= '0;
          gnt_valid <= 1'b0;
        end
      endcase
      if (MODE == 0) ptr <= LAST_IDX;
    end
  end

endmodule

// File: tb/tb_prio_arbiter.sv
// tb_prio_arbiter: directed checks of prio_arbiter in fixed-priority (N=8),
// round-robin (N=8) and non-power-of-two round-robin (N=5) configurations.
module tb_prio_arbiter;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [7:0] req_f, gnt_f;
  logic [2:0] idx_f;
  logic       done_f, valid_f;

  logic [7:0] req_r, gnt_r;
  logic [2:0] idx_r;
  logic       done_r, valid_r;

  logic [4:0] req_5, gnt_5;
  logic [2:0] idx_5;
  logic       done_5, valid_5;

  prio_arbiter #(.N(8), .MODE(0)) u_fix (
    .clk(clk), .rst(rst), .req(req_f), .done(done_f),
    .gnt(gnt_f), .gnt_idx(idx_f), .gnt_valid(valid_f)
  );

  prio_arbiter #(.N(8), .MODE(1)) u_rr (
    .clk(clk), .rst(rst), .req(req_r), .done(done_r),
    .gnt(gnt_r), .gnt_idx(idx_r), .gnt_valid(valid_r)
  );

  prio_arbiter #(.N(5), .MODE(1)) u_rr5 (
    .clk(clk), .rst(rst), .req(req_5), .done(done_5),
    .gnt(gnt_5), .gnt_idx(idx_5), .gnt_valid(valid_5)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_f(input string tag, input logic [7:0] g, input logic [2:0] i, input logic v);
    check({tag, ".gnt"}, gnt_f, g);
    check({tag, ".idx"}, idx_f, i);
    check({tag, ".valid"}, valid_f, v);
  endtask

  task automatic check_r(input string tag, input logic [7:0] g, input logic [2:0] i, input logic v);
    check({tag, ".gnt"}, gnt_r, g);
    check({tag, ".idx"}, idx_r, i);
    check({tag, ".valid"}, valid_r, v);
  endtask

  task automatic check_5(input string tag, input logic [4:0] g, input logic [2:0] i, input logic v);
    check({tag, ".gnt"}, gnt_5, g);
    check({tag, ".idx"}, idx_5, i);
    check({tag, ".valid"}, valid_5, v);
  endtask

  // ---------------- stimulus ----------------
  logic [2:0] rr_seq [8];
  logic [2:0] rr5_seq [5];

  initial begin
    rr_seq  = '{3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};
    rr5_seq = '{3'd3, 3'd2, 3'd1, 3'd0, 3'd4};

    rst = 1'b1;
    req_f = '0; done_f = 1'b0;
    req_r = '0; done_r = 1'b0;
    req_5 = '0; done_5 = 1'b0;
    tick();
    tick();
    check_f("reset_fix", 8'h00, 3'd0, 1'b0);
    check_r("reset_rr", 8'h00, 3'd0, 1'b0);
    check_5("reset_rr5", 5'h00, 3'd0, 1'b0);
    rst = 1'b0;
    tick();
    check_f("idle_noreq", 8'h00, 3'd0, 1'b0);

    // ---- fixed priority ----
    req_f = 8'b0010_1001;
    tick();
    check_f("fix_win5", 8'b0010_0000, 3'd5, 1'b1);
    done_f = 1'b1;
    req_f  = 8'b0000_1001;
    tick();
    check_f("fix_rel5", 8'h00, 3'd0, 1'b0);
    done_f = 1'b0;
    tick();
    check_f("fix_win3", 8'b0000_1000, 3'd3, 1'b1);
    req_f = 8'b1000_1001;
    tick();
    check_f("fix_hold3", 8'b0000_1000, 3'd3, 1'b1);
    req_f = 8'b1000_0001;
    tick();
    check_f("fix_abandon3", 8'h00, 3'd0, 1'b0);
    tick();
    check_f("fix_win7", 8'h80, 3'd7, 1'b1);
    done_f = 1'b1;
    tick();
    check_f("fix_done7", 8'h00, 3'd0, 1'b0);
    done_f = 1'b0;
    tick();
    check_f("fix_regrant7", 8'h80, 3'd7, 1'b1);
    done_f = 1'b1;
    req_f  = 8'h00;
    tick();
    check_f("fix_both_rel", 8'h00, 3'd0, 1'b0);
    tick();
    check_f("fix_done_idle", 8'h00, 3'd0, 1'b0);
    done_f = 1'b0;

    // ---- round-robin fairness, req all ones ----
    req_r = 8'hFF;
    tick();
    check_r("rr_first7", 8'h80, 3'd7, 1'b1);
    for (int s = 0; s < 8; s++) begin
      done_r = 1'b1;
      tick();
      check_r($sformatf("rr_gap%0d", s), 8'h00, 3'd0, 1'b0);
      done_r = 1'b0;
      tick();
      check_r($sformatf("rr_seq%0d", s), 8'(1) << rr_seq[s], rr_seq[s], 1'b1);
    end

    // ---- round-robin wrap and skip ----
    done_r = 1'b1;
    tick();
    check_r("rr_rel7", 8'h00, 3'd0, 1'b0);
    done_r = 1'b0;
    req_r  = 8'h01;
    tick();
    check_r("rr_win0", 8'h01, 3'd0, 1'b1);
    done_r = 1'b1;
    req_r  = 8'h00;
    tick();
    check_r("rr_rel0_both", 8'h00, 3'd0, 1'b0);
    done_r = 1'b0;
    req_r  = 8'b0100_0010;
    tick();
    check_r("rr_wrap6", 8'b0100_0000, 3'd6, 1'b1);
    done_r = 1'b1;
    tick();
    check_r("rr_rel6", 8'h00, 3'd0, 1'b0);
    done_r = 1'b0;
    tick();
    check_r("rr_skip1", 8'b0000_0010, 3'd1, 1'b1);
    req_r = 8'b0100_0000;
    tick();
    check_r("rr_abandon1", 8'h00, 3'd0, 1'b0);
    req_r = 8'b0100_0010;
    tick();
    check_r("rr_after_abandon6", 8'b0100_0000, 3'd6, 1'b1);

    // ---- non-power-of-two round robin ----
    req_5 = 5'b11111;
    tick();
    check_5("rr5_first4", 5'b10000, 3'd4, 1'b1);
    for (int s = 0; s < 5; s++) begin
      done_5 = 1'b1;
      tick();
      check_5($sformatf("rr5_gap%0d", s), 5'h00, 3'd0, 1'b0);
      done_5 = 1'b0;
      tick();
      check_5($sformatf("rr5_seq%0d", s), 5'(1) << rr5_seq[s], rr5_seq[s], 1'b1);
      check($sformatf("rr5_range%0d", s), 64'(idx_5 <= 3'd4), 64'd1);
    end

    // ---- asynchronous reset during GRANT ----
    req_f = 8'hFF;
    req_r = 8'hFF;
    tick();
    check_f("pre_rst_fix", 8'h80, 3'd7, 1'b1);
    check_r("pre_rst_rr_hold6", 8'b0100_0000, 3'd6, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_f("async_rst_fix", 8'h00, 3'd0, 1'b0);
    check_r("async_rst_rr", 8'h00, 3'd0, 1'b0);
    check_5("async_rst_rr5", 5'h00, 3'd0, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    check_f("post_rst_fix", 8'h80, 3'd7, 1'b1);
    check_r("post_rst_rr_ptr7", 8'h80, 3'd7, 1'b1);
    check_5("post_rst_rr5_ptr4", 5'b10000, 3'd4, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/prio_arbiter.md
# prio_arbiter

Parametrised, registered priority arbiter for N requesters. It is the sequential successor to the 8-input priority encoder. The arbiter selects one winner from a request vector, holds that grant until the winner releases it, and reports both a one-hot grant and a binary grant index. A mode parameter selects fixed priority, where the highest index wins, or round-robin priority with a rotating pointer. It sits between multiple masters and a single shared resource.

## Interface
- N, default 8: number of requesters. Legal range 2..64.
- W, default $clog2(N): width of the binary grant index.
- MODE, default 0: 0 selects fixed priority (index N-1 highest). 1 selects round-robin.

- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req  input  N  request vector; req[k]=1 means requester k wants the resource.
- done  input  1  single-cycle release pulse from the current owner.
- gnt  output  N  registered one-hot grant; all zeros when no grant is held.
- gnt_idx  output  W  registered binary index of the grant holder; 0 when no grant is held.
- gnt_valid  output  1  registered flag; 1 while a grant is held (equals |gnt).

## Operation
- **Two-state FSM: IDLE, GRANT.** All outputs are registered.
- **IDLE.**
  - If |req=1, compute winner g, load gnt=1<<g, gnt_idx=g, gnt_valid=1, and go to GRANT.
  - Otherwise stay in IDLE with outputs zero.
  - done is ignored in IDLE.
- **Winner, MODE=0.** g is the highest set index of req.
- **Winner, MODE=1.** Search starts at pointer ptr and descends ptr, ptr-1, …, 0, then N-1, …, ptr+1. g is the first set bit found.
- **GRANT.** The grant is held unchanged, and changes to other req bits are ignored. A release happens when either:
  - done=1, or
  - req[g]=0 (abandon).
- **On release.**
  - Next cycle: gnt=0, gnt_idx=0, gnt_valid=0, state IDLE.
  - MODE=1 only: ptr <= (g==0) ? N-1 : g-1.
  - done and req[g] falling in the same cycle count as one release.
- **No back-to-back grants.** After every release, at least one cycle with gnt_valid=0 is guaranteed.
- **ptr.**
  - Width W, internal.
  - Unused and held at N-1 when MODE=0.
  - Wraps modulo N; never takes a value ≥ N when N is not a power of two.
- **Reset value of every output.** gnt=0, gnt_idx=0, gnt_valid=0; also state=IDLE, ptr=N-1.
- **Reset during GRANT.** The grant is dropped asynchronously, and the pointer returns to N-1.

## Timing
- **Grant latency.** req sampled at edge k gives the grant visible after edge k, i.e. one cycle of latency.
- **Release latency.** done sampled at edge k gives gnt=0 after edge k.
- **Minimum re-grant.** The next grant is visible after edge k+1, so the minimum grant-to-grant period is 2 cycles plus the hold time.
- **Reset.**
  - Assertion takes effect immediately, with no clock required.
  - Deassertion must meet recovery time to clk.
  - On the first edge after deassertion, arbitration proceeds normally.
- **Constant outputs.** gnt, gnt_idx and gnt_valid are mutually consistent at every cycle; there is no combinational path from req/done to any output.

## Test plan
- **Reset:** assert rst mid-simulation with req=8'hFF held -> gnt=0, gnt_idx=0, gnt_valid=0 immediately, before any clk edge. Release rst -> gnt=8'h80 and gnt_idx=7 after the next edge.
- **Fixed priority (MODE=0, N=8):**
  - req=8'b0010_1001 -> after 1 edge gnt=8'b0010_0000, gnt_idx=5.
  - Pulse done and clear req[5] -> next edge gnt=0.
  - Following edge -> gnt=8'b0000_1000, gnt_idx=3.
- **Round-robin fairness (MODE=1, N=8):** req=8'hFF held, done pulsed once in each grant cycle -> gnt_idx sequence 7,6,5,4,3,2,1,0,7, each separated by one gnt_valid=0 cycle.
- **Round-robin wrap and skip (MODE=1):**
  - Grant 0 and release it, so ptr becomes 7.
  - Then req=8'b0100_0010 -> gnt_idx=6.
  - Release -> ptr=5. Same req -> gnt_idx=1.
- **Abandon and simultaneity:**
  - Drop req[g] with done=0 -> release after 1 edge.
  - Drop req[g] with done=1 in the same cycle -> exactly one release, and ptr advances once.
  - Pulse done in IDLE -> no effect.
- **Non-power-of-two (N=5, MODE=1):** req=5'b11111 cycled through grants -> gnt_idx sequence 4,3,2,1,0,4. gnt_idx never exceeds 4.
